aes_round_ctrl: RTL and testbench
=================================

// Module: aes_round_ctrl
// PURPOSE
//  Iterative AES-128 encryption sequencer. Owns the round FSM and round counter.
//  Drives the enables and selects of the shared round datapath (subBytes -> shiftRows
//  -> mixColumns -> addRoundKey) and of the 128-bit state register.
//  Handshakes with the key-expansion unit for each round key and with the consumer
//  for the ciphertext.
// PARAMETERS
//  NR     10  number of rounds after the initial addRoundKey (10 for AES-128)
//  RIDX_W 4   width of round_idx; must satisfy 2**RIDX_W > NR
// PORTS
//  clk          in   1       clock; all state updates on rising edge
//  rst_n        in   1       asynchronous reset, active-low
//  start        in   1       request a new block; accepted only when in_ready=1
//  in_ready     out  1       1 in IDLE; accepts start
//  key_req      out  1       round key round_idx requested from key expansion
//  key_valid    in   1       requested round key present this cycle
//  round_idx    out  RIDX_W  index of the key / round currently being processed
//  load_in      out  1       state_reg <= plaintext ^ key0 this cycle
//  round_en     out  1       state_reg <= round(state_reg, key[round_idx]) this cycle
//  last_round   out  1       datapath bypasses mixColumns (round_idx==NR)
//  busy         out  1       1 in KEY0 / ROUND / OUT
//  out_valid    out  1       ciphertext in state_reg is valid; held until out_ready
//  out_ready    in   1       consumer accepts ciphertext
//  done         out  1       1-cycle pulse on the out_valid&out_ready cycle
//  abort        in   1       present only with AES_ABORT_EN
// BEHAVIOUR
//  Reset (async, rst_n=0): FSM=IDLE, round_idx=0.
//   Reset values: in_ready=1; every other output = 0.
//  States:
//   IDLE  -> KEY0 on start. Start is ignored in all other states (no queueing).
//   KEY0  : key_req=1, round_idx=0. load_in = key_valid.
//           key_valid=1 -> round_idx<=1, go ROUND. Otherwise stay (stall, no update).
//   ROUND : key_req=1. round_en = key_valid. last_round = (round_idx==NR).
//           key_valid=1 and round_idx<NR -> round_idx++.
//           key_valid=1 and round_idx==NR -> go OUT, round_idx<=0.
//           key_valid=0 -> hold everything. Stalls are unbounded.
//   OUT   : out_valid=1. out_valid&out_ready -> done=1, go IDLE.
//           A start in that same cycle is ignored, because in_ready=0 in OUT.
//  Output decode:
//   load_in, round_en, done: combinational from state & handshake input.
//   All other outputs: decoded from registered state only.
//   key_req, load_in and round_en are never active outside KEY0/ROUND.
//   load_in and round_en are never both 1.
//  Latency: with key_valid and out_ready tied 1, start cycle T gives
//   KEY0 at T+1, ROUND at T+2 .. T+NR+1, out_valid at T+NR+2 (T+12 for NR=10).
//   Throughput: one block per NR+3 cycles.
//  round_idx never exceeds NR and never wraps.
//  Reset asserted mid-operation: immediate return to IDLE. The partial block is
//   discarded and no done pulse is produced.
// CONFIGURATION
//  AES_ABORT_EN defined:
//   Adds input abort (1 bit). abort=1 in any state -> next cycle IDLE, round_idx=0,
//   no done pulse. abort has priority over start, key_valid and out_ready.
//  AES_ABORT_EN undefined:
//   No abort port. The only way out of a block is completion or rst_n.
// TESTING
//  1 Reset: rst_n=0 mid-ROUND (round_idx=5) -> same cycle in_ready=1, round_idx=0,
//    all other outputs 0.
//  2 Nominal: key_valid=1, out_ready=1, start at T ->
//    load_in@T+1; round_en@T+2..T+11 with round_idx 1..10; last_round only @T+11;
//    out_valid and done @T+12.
//  3 Key stall: key_valid=0 for 3 cycles at round_idx=4 ->
//    round_idx stays 4, round_en=0, key_req=1; out_valid is 3 cycles late (T+15).
//  4 Output backpressure: out_ready=0 for 5 cycles ->
//    out_valid held, done=0; start pulses ignored; done on the first out_ready=1.
//  5 Start while busy: start every cycle -> exactly one block per 13 cycles,
//    round_idx sequence 0..10 each time.
//  6 AES_ABORT_EN: abort at round_idx=7 -> IDLE next cycle, no done;
//    a following start completes normally after 12 cycles.

Source files
------------

// File: rtl/aes_round_ctrl.sv
// aes_round_ctrl: iterative AES-128 encryption sequencer.
// Owns the round FSM and the round counter, drives the enables and selects of the
// shared round datapath, and handshakes with key expansion and the ciphertext consumer.
// Optional feature macro: AES_ABORT_EN adds an 'abort' input that returns the FSM
// to IDLE from any state without a done pulse.
module aes_round_ctrl #(
  parameter int NR     = 10,
  parameter int RIDX_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              in_ready,
  output logic              key_req,
  input  logic              key_valid,
  output logic [RIDX_W-1:0] round_idx,
  output logic              load_in,
  output logic              round_en,
  output logic              last_round,
  output logic              busy,
  output logic              out_valid,
  input  logic              out_ready,
`ifdef AES_ABORT_EN
  input  logic              abort,
`endif
  output logic              done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    KEY0  = 2'd1,
    ROUND = 2'd2,
    OUT   = 2'd3
  } state_t;

  localparam logic [RIDX_W-1:0] NR_IDX  = RIDX_W'(NR);
  localparam logic [RIDX_W-1:0] IDX_ONE = RIDX_W'(1);

  state_t            state_q, state_d;
  logic [RIDX_W-1:0] round_idx_q, round_idx_d;

  // State and round counter registers; reset discards any partial block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      round_idx_q <= '0;
    end else begin
      state_q     <= state_d;
      round_idx_q <= round_idx_d;
    end
  end

  // Next-state logic plus the handshake-dependent strobes (load_in, round_en, done).
  always_comb begin
    state_d     = state_q;
    round_idx_d = round_idx_q;
    load_in     = 1'b0;
    round_en    = 1'b0;
    done        = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = KEY0;
          round_idx_d = '0;
        end
      end
      KEY0: begin
        load_in = key_valid;
        if (key_valid) begin
          state_d     = ROUND;
          round_idx_d = IDX_ONE;
        end
      end
      ROUND: begin
        round_en = key_valid;
        if (key_valid) begin
          if (round_idx_q == NR_IDX) begin
            state_d     = OUT;
            round_idx_d = '0;
          end else begin
            round_idx_d = round_idx_q + IDX_ONE;
          end
        end
      end
      OUT: begin
        done = out_ready;
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d     = IDLE;
        round_idx_d = '0;
      end
    endcase
`ifdef AES_ABORT_EN
    if (abort) begin
      state_d     = IDLE;
      round_idx_d = '0;
      load_in     = 1'b0;
      round_en    = 1'b0;
      done        = 1'b0;
    end
`endif
  end

  // Outputs decoded purely from registered state so they are glitch-free.
  always_comb begin
    in_ready   = (state_q == IDLE);
    key_req    = (state_q == KEY0) || (state_q == ROUND);
    busy       = (state_q != IDLE);
    out_valid  = (state_q == OUT);
    last_round = (state_q == ROUND) && (round_idx_q == NR_IDX);
    round_idx  = round_idx_q;
  end

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Testbench for aes_round_ctrl: directed scenarios with a scoreboard of expected
// datapath strobes (load_in / round_en / done) checked by an independent monitor.
module tb_aes_round_ctrl;

  localparam int NR     = 10;
  localparam int RIDX_W = 4;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic              in_ready;
  logic              key_req;
  logic              key_valid;
  logic [RIDX_W-1:0] round_idx;
  logic              load_in;
  logic              round_en;
  logic              last_round;
  logic              busy;
  logic              out_valid;
  logic              out_ready;
  logic              done;
`ifdef AES_ABORT_EN
  logic              abort;
`endif

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // One expected strobe: kind 0=load_in, 1=round_en, 2=done
  typedef struct {
    int kind;
    int idx;
    int last;
    int at;
  } ev_t;

  ev_t expQ[$];

  aes_round_ctrl #(.NR(NR), .RIDX_W(RIDX_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .in_ready  (in_ready),
    .key_req   (key_req),
    .key_valid (key_valid),
    .round_idx (round_idx),
    .load_in   (load_in),
    .round_en  (round_en),
    .last_round(last_round),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef AES_ABORT_EN
    .abort     (abort),
`endif
    .done      (done)
  );

  // 10 ns clock and a free-running cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Safety net so the run can never hang
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s: actual=%0d required=%0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic pushEv(input int kind, input int idx, input int last, input int at);
    ev_t e;
    e.kind = kind;
    e.idx  = idx;
    e.last = last;
    e.at   = at;
    expQ.push_back(e);
  endtask

  // Expected strobes for one block started at cycle t; events at or after the
  // cutoff (relative to t) are not expected because reset/abort kills them.
  task automatic pushBlock(input int t, input int stallAt, input int stallLen,
                           input int bpLen, input int cutoff);
    int r;
    if (1 < cutoff) pushEv(0, 0, 0, t + 1);
    for (int i = 1; i <= NR; i++) begin
      r = 1 + i + ((stallLen > 0 && i >= stallAt) ? stallLen : 0);
      if (r < cutoff) pushEv(1, i, (i == NR) ? 1 : 0, t + r);
    end
    r = NR + 2 + stallLen + bpLen;
    if (r < cutoff) pushEv(2, 0, 0, t + r);
  endtask

  // Monitor: pops and compares whenever the DUT presents a datapath strobe
  always @(negedge clk) begin
    int kind;
    ev_t e;
    if (rst_n) begin
      if (load_in && round_en) checkOutput("load_round_exclusive", 1, 0);
      if (load_in || round_en || done) begin
        kind = load_in ? 0 : (round_en ? 1 : 2);
        if (expQ.size() == 0) begin
          checkOutput("unexpected_event", kind, -1);
        end else begin
          e = expQ.pop_front();
          checkOutput("ev_kind", kind, e.kind);
          checkOutput("ev_cycle", cyc, e.at);
          if (kind == 1) begin
            checkOutput("ev_round_idx", int'(round_idx), e.idx);
            checkOutput("ev_last_round", int'(last_round), e.last);
          end
        end
      end
    end
  end

  // Drive one cycle of inputs shortly after the rising edge
  task automatic applyStimulus(input logic s, input logic kv, input logic ordy, input logic ab);
    start     = s;
    key_valid = kv;
    out_ready = ordy;
`ifdef AES_ABORT_EN
    abort     = ab;
`else
    if (ab) $display("[TB] abort requested without AES_ABORT_EN");
`endif
  endtask

  // Runs nBlocks blocks; stall/backpressure apply to single-block runs.
  // rstAt / abortAt >= 0 kill the block at that relative cycle.
  task automatic runScenario(input int stallAt, input int stallLen, input int bpLen,
                             input int nBlocks, input int rstAt, input int abortAt);
    int t0, len, cutoff, rel;
    logic s, kv, ordy, ab;
    bit inBp;
    len    = 13 * nBlocks + stallLen + bpLen + 1;
    cutoff = (rstAt >= 0) ? rstAt : ((abortAt >= 0) ? abortAt : 1000);
    @(posedge clk);
    #1;
    t0 = cyc;
    for (int b = 0; b < nBlocks; b++) pushBlock(t0 + 13 * b, stallAt, stallLen, bpLen, cutoff);
    for (rel = 0; rel < len; rel++) begin
      if (rel > 0) begin
        @(posedge clk);
        #1;
      end
      inBp = (rel >= NR + 2 + stallLen) && (rel < NR + 2 + stallLen + bpLen);
      if (nBlocks > 1) s = (rel < 13 * nBlocks);
      else             s = (rel == 0) || (inBp && rel[0]);
      kv   = !(stallLen > 0 && rel >= stallAt + 1 && rel <= stallAt + stallLen);
      ordy = !inBp;
      ab   = (rel == abortAt);
      if (rstAt >= 0 && rel > rstAt) begin
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
        rst_n = 1'b1;
        break;
      end
      if (abortAt >= 0 && rel > abortAt) begin
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
        #1;
        checkOutput("abort_in_ready", int'(in_ready), 1);
        checkOutput("abort_round_idx", int'(round_idx), 0);
        checkOutput("abort_busy", int'(busy), 0);
        break;
      end
      applyStimulus(s, kv, ordy, ab);
      #1;
      if (rel == 0) checkOutput("idle_in_ready", int'(in_ready), 1);
      if (rel == 1) begin
        checkOutput("key0_busy", int'(busy), 1);
        checkOutput("key0_key_req", int'(key_req), 1);
        checkOutput("key0_in_ready", int'(in_ready), 0);
        checkOutput("key0_round_idx", int'(round_idx), 0);
      end
      if (!kv && nBlocks == 1) begin
        checkOutput("stall_round_idx", int'(round_idx), stallAt);
        checkOutput("stall_round_en", int'(round_en), 0);
        checkOutput("stall_key_req", int'(key_req), 1);
      end
      if (inBp) begin
        checkOutput("bp_out_valid", int'(out_valid), 1);
        checkOutput("bp_done", int'(done), 0);
      end
      if (nBlocks == 1 && rel == NR + 2 + stallLen + bpLen && rstAt < 0 && abortAt < 0)
        checkOutput("final_out_valid", int'(out_valid), 1);
      if (rel == rstAt) begin
        rst_n = 1'b0;
        #1;
        checkOutput("rst_in_ready", int'(in_ready), 1);
        checkOutput("rst_round_idx", int'(round_idx), 0);
        checkOutput("rst_busy", int'(busy), 0);
        checkOutput("rst_key_req", int'(key_req), 0);
        checkOutput("rst_round_en", int'(round_en), 0);
        checkOutput("rst_out_valid", int'(out_valid), 0);
        expQ.delete();
      end
    end
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_in_ready", int'(in_ready), 1);
    checkOutput("reset_key_req", int'(key_req), 0);
    checkOutput("reset_round_idx", int'(round_idx), 0);
    checkOutput("reset_load_in", int'(load_in), 0);
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_out_valid", int'(out_valid), 0);
    checkOutput("reset_done", int'(done), 0);
    rst_n = 1'b1;

    $display("[TB] nominal block");
    runScenario(0, 0, 0, 1, -1, -1);
    $display("[TB] key stall at round 4");
    runScenario(4, 3, 0, 1, -1, -1);
    $display("[TB] output backpressure");
    runScenario(0, 0, 5, 1, -1, -1);
    $display("[TB] start held every cycle");
    runScenario(0, 0, 0, 3, -1, -1);
    $display("[TB] reset at round 5");
    runScenario(0, 0, 0, 1, 6, -1);
    runScenario(0, 0, 0, 1, -1, -1);
`ifdef AES_ABORT_EN
    $display("[TB] abort at round 7");
    runScenario(0, 0, 0, 1, -1, 8);
    runScenario(0, 0, 0, 1, -1, -1);
`endif

    repeat (3) @(posedge clk);
    #1;
    checkOutput("scoreboard_drained", expQ.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
